sha_round_counter: RTL and testbench

//   Round/address counter for the SHA hashing datapath. Counts 0..MAX_CNT

---
 rtl/sha_round_counter.sv | 39 +++
 tb/tb_sha_round_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha_round_counter.sv
// rtl/sha_round_counter.sv - round/address counter with terminal flag for the SHA datapath
module sha_round_counter #(
  parameter int unsigned MAX_CNT  = 63,
  parameter int unsigned CNT_SIZE = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_cnt_en,
  output logic                flag,
  output logic [CNT_SIZE-1:0] count
);

  // Terminal value and unit step expressed in the counter's own width.
  localparam logic [CNT_SIZE-1:0] MAX_VAL = CNT_SIZE'(MAX_CNT);
  localparam logic [CNT_SIZE-1:0] ONE     = CNT_SIZE'(1);

  logic at_max;

  assign at_max = (count == MAX_VAL);

  // Advance on enable, wrapping explicitly at MAX_CNT so a non-power-of-two
  // terminal count never reaches the unused upper codes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (i_cnt_en) begin
      if (at_max) begin
        count <= '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

  // The flag follows the count directly, so it stays high while the
  // counter is parked at the terminal value with enable low.
  assign flag = at_max;

endmodule

// File: tb/tb_sha_round_counter.sv
// tb/tb_sha_round_counter.sv - scoreboard bench for sha_round_counter (default and 0..5 configurations)
module tb_sha_round_counter;

  localparam int BIG_MAX   = 63;
  localparam int SMALL_MAX = 5;

  logic       clk;
  logic       reset_n;
  logic       i_cnt_en;
  logic       flag_b;
  logic [5:0] count_b;
  logic       flag_s;
  logic [2:0] count_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int c;
    int f;
  } exp_t;

  exp_t qb[$];
  exp_t qs[$];
  int   mb;
  int   ms;

  sha_round_counter dut_big (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_cnt_en (i_cnt_en),
    .flag     (flag_b),
    .count    (count_b)
  );

  sha_round_counter #(.MAX_CNT(SMALL_MAX), .CNT_SIZE(3)) dut_small (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_cnt_en (i_cnt_en),
    .flag     (flag_s),
    .count    (count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference rule: enabled rounds go modulo (max+1), disabled rounds hold.
  function automatic int nxt(input int m, input bit en, input int mx);
    if (!en) return m;
    return (m + 1) % (mx + 1);
  endfunction

  task automatic step(input bit en);
    exp_t e;
    @(negedge clk);
    i_cnt_en = en;
    mb = nxt(mb, en, BIG_MAX);
    ms = nxt(ms, en, SMALL_MAX);
    e.c = mb; e.f = (mb == BIG_MAX) ? 1 : 0; qb.push_back(e);
    e.c = ms; e.f = (ms == SMALL_MAX) ? 1 : 0; qs.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_big_count"}, int'(count_b), 0);
    chk({tag, "_big_flag"}, int'(flag_b), 0);
    chk({tag, "_small_count"}, int'(count_s), 0);
    chk({tag, "_small_flag"}, int'(flag_s), 0);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      i_cnt_en = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end
    @(negedge clk);
    i_cnt_en = 1'b0;
    reset_n  = 1'b1;
    mb = 0;
    ms = 0;
  endtask

  // Monitor: after each active edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("big_count", int'(count_b), e.c);
        chk("big_flag", int'(flag_b), e.f);
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        chk("small_count", int'(count_s), e.c);
        chk("small_flag", int'(flag_s), e.f);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    i_cnt_en = 1'b0;
    mb = 0;
    ms = 0;
    #3;
    chk_zero("reset");
    repeat (4) begin
      @(negedge clk);
      i_cnt_en = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("reset_idle");
    end

    @(negedge clk);
    reset_n = 1'b1;

    // Full run through terminal count and wrap.
    repeat (BIG_MAX + 2) step(1'b1);

    // Continue to 10, pause five edges, resume.
    while (mb != 10) step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);

    // Park at the terminal value with enable low, then wrap on resume.
    while (mb != BIG_MAX) step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);

    // Reset in the middle of a count.
    while (mb != 37) step(1'b1);
    mid_reset();

    // Randomized enable pattern with one extra asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (qb.size() != 0 || qs.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d required=0 pending", qb.size() + qs.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
